// File: rtl/sr_pulse_debouncer_pkg.sv
// Shared definitions for the R-S latch push-button front end.
//
// Contents:
//   DEFAULT_DEBOUNCE_CYCLES : default stable-time requirement in clk cycles
//   DEFAULT_SYNC_STAGES     : default synchroniser depth
//   clog2()                 : ceiling log2, used to size the debounce counter
package sr_pulse_debouncer_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

  // Ceiling log2 for elaboration-time sizing; clog2(5) = 3, clog2(4) = 2.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: synchroniser, debounce counter, stable level and
// press (rising edge of the stable level) detection.
//
// Ports:
//   clk     : system clock, all state on the rising edge
//   reset   : synchronous active-high reset, clears every flop
//   btn_i   : raw asynchronous button, active-high
//   level_o : debounced (stable) level
//   rise_o  : combinational; high when the coming edge flips stable 0 -> 1.
//             The parent registers it so the strobe lines up with the flip.
module debounce_channel
  import sr_pulse_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,  // 1..65535
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES       // 2..3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned           CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    sync_d   = {sync_q[SYNC_STAGES-2:0], btn_i};
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync != stable_q) begin
      // The D-th consecutive differing edge flips the level. The counter
      // only advances below CNT_LAST, so it saturates instead of wrapping.
      if (cnt_q >= CNT_LAST) begin
        stable_d = sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign rise_o  = stable_d & ~stable_q;
  assign level_o = stable_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    // NOTE: the synchroniser flops are reset too, so a button held through
    // reset is seen as a fresh press once reset drops.
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/sr_pulse_debouncer.sv
// Front end for the board's R-S latch: debounces btn_set / btn_reset and
// turns their presses into clean one-cycle S / R strobes, keeps a clocked
// reference copy of the latch state and flags simultaneous S+R requests.
//
// Ports:
//   clk         : system clock
//   reset       : synchronous active-high reset
//   btn_set     : raw set button (async, active-high)
//   btn_reset   : raw reset button (async, active-high)
//   s_pulse     : one-cycle strobe on a debounced set press (latch S)
//   r_pulse     : one-cycle strobe on a debounced reset press (latch R)
//   set_level   : debounced btn_set level
//   reset_level : debounced btn_reset level
//   q           : reference latch state, follows the strobes one edge later
//   conflict    : one-cycle flag, both presses resolved on the same edge
module sr_pulse_debouncer
  import sr_pulse_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_reset,
  output logic s_pulse,
  output logic r_pulse,
  output logic set_level,
  output logic reset_level,
  output logic q,
  output logic conflict
);

  logic set_rise, reset_rise;
  logic s_pulse_q, s_pulse_d;
  logic r_pulse_q, r_pulse_d;
  logic conflict_q, conflict_d;
  logic q_q, q_d;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_set_chan (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_set),
    .level_o (set_level),
    .rise_o  (set_rise)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_reset_chan (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_reset),
    .level_o (reset_level),
    .rise_o  (reset_rise)
  );

  // Presses resolving on the same edge cancel each other and raise
  // conflict instead, so S and R can never be strobed together.
  always_comb begin
    s_pulse_d  = set_rise & ~reset_rise;
    r_pulse_d  = reset_rise & ~set_rise;
    conflict_d = set_rise & reset_rise;
    q_d        = q_q;
    if (s_pulse_q) begin
      q_d = 1'b1;
    end else if (r_pulse_q) begin
      q_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_pulse_q  <= 1'b0;
      r_pulse_q  <= 1'b0;
      conflict_q <= 1'b0;
      q_q        <= 1'b0;
    end else begin
      s_pulse_q  <= s_pulse_d;
      r_pulse_q  <= r_pulse_d;
      conflict_q <= conflict_d;
      q_q        <= q_d;
    end
  end

  assign s_pulse  = s_pulse_q;
  assign r_pulse  = r_pulse_q;
  assign conflict = conflict_q;
  assign q        = q_q;

endmodule

// File: tb/tb_sr_pulse_debouncer.sv
// Self-checking bench for sr_pulse_debouncer (default parameters).
// A reference model built from the stated rules (raw-sample history,
// run length of differing samples, press resolution) predicts every output
// each cycle; directed scenarios add latency and strobe-count checks.
module tb_sr_pulse_debouncer;

  localparam int D = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset, btn_set, btn_reset;
  logic s_pulse, r_pulse, set_level, reset_level, q, conflict;

  int n_vec  = 0;
  int n_fail = 0;

  sr_pulse_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_set     (btn_set),
    .btn_reset   (btn_reset),
    .s_pulse     (s_pulse),
    .r_pulse     (r_pulse),
    .set_level   (set_level),
    .reset_level (reset_level),
    .q           (q),
    .conflict    (conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit raw_s[$];
  bit raw_r[$];
  int edge_n   = 0;
  int last_rst = -1;
  bit m_stab[2];
  int m_run[2];
  bit m_sp, m_rp, m_cf, m_q;

  // The value a channel compares at edge m is the raw sample captured
  // S edges earlier, unless a reset edge came at or after that capture.
  function automatic bit sync_seen(input int c, input int m);
    int idx;
    idx = m - S;
    if (idx < 0 || idx <= last_rst) return 1'b0;
    return (c == 0) ? raw_s[idx] : raw_r[idx];
  endfunction

  task automatic model_edge(input bit s, input bit r, input bit rst);
    bit rise[2];
    bit sy;
    raw_s.push_back(s);
    raw_r.push_back(r);
    if (rst) begin
      last_rst = edge_n;
      for (int c = 0; c < 2; c++) begin
        m_stab[c] = 1'b0;
        m_run[c]  = 0;
      end
      m_sp = 1'b0; m_rp = 1'b0; m_cf = 1'b0; m_q = 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        rise[c] = 1'b0;
        sy = sync_seen(c, edge_n);
        if (sy != m_stab[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_stab[c] = sy;
            m_run[c]  = 0;
            rise[c]   = sy;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      if (m_sp) m_q = 1'b1;
      else if (m_rp) m_q = 1'b0;
      m_sp = rise[0] && !rise[1];
      m_rp = rise[1] && !rise[0];
      m_cf = rise[0] && rise[1];
    end
    edge_n++;
  endtask

  // ---------------- stimulus ----------------
  int n_sp = 0, n_rp = 0, n_cf = 0, n_rlvl = 0;

  task automatic step(input bit s, input bit r, input bit rst);
    @(negedge clk);
    btn_set = s; btn_reset = r; reset = rst;
    @(posedge clk);
    model_edge(s, r, rst);
    #1;
    check("s_pulse",     s_pulse,     int'(m_sp));
    check("r_pulse",     r_pulse,     int'(m_rp));
    check("conflict",    conflict,    int'(m_cf));
    check("q",           q,           int'(m_q));
    check("set_level",   set_level,   int'(m_stab[0]));
    check("reset_level", reset_level, int'(m_stab[1]));
    if (s_pulse === 1'b1) n_sp++;
    if (r_pulse === 1'b1) n_rp++;
    if (conflict === 1'b1) n_cf++;
    if (reset_level === 1'b1) n_rlvl++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int first_s, first_r, b_sp, b_rp, b_cf, b_rl;
    bit q_before;
    bit bounce[6];
    bit cs, cr;
    int len;

    btn_set = 1'b0; btn_reset = 1'b0; reset = 1'b1;

    // Reset with btn_set held, then release with it still held.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    check("rst_s_pulse", s_pulse, 0);
    check("rst_q", q, 0);
    check("rst_set_level", set_level, 0);
    first_s = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (s_pulse === 1'b1 && first_s < 0) first_s = i;
      if (i == 6) check("rst_rel_q_set", q, 1);
    end
    check("rst_rel_latency", first_s, 5);
    check("rst_rel_level", set_level, 1);

    // Clean set press then clean reset press.
    idle(10);
    b_sp = n_sp; b_rp = n_rp;
    first_s = -1;
    for (int i = 0; i < 20; i++) begin
      step(i < 10, 1'b0, 1'b0);
      if (s_pulse === 1'b1 && first_s < 0) first_s = i;
    end
    check("clean_set_latency", first_s, 5);
    check("clean_set_q", q, 1);
    first_r = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, i < 10, 1'b0);
      if (r_pulse === 1'b1 && first_r < 0) first_r = i;
    end
    check("clean_rst_latency", first_r, 5);
    check("clean_rst_q", q, 0);
    check("clean_s_count", n_sp - b_sp, 1);
    check("clean_r_count", n_rp - b_rp, 1);

    // Bouncing set: 1,0,1,1,0,1 then held; last rising sample is index 5.
    idle(10);
    bounce = '{1, 0, 1, 1, 0, 1};
    b_sp = n_sp;
    first_s = -1;
    for (int i = 0; i < 16; i++) begin
      step((i < 6) ? bounce[i] : 1'b1, 1'b0, 1'b0);
      if (s_pulse === 1'b1 && first_s < 0) first_s = i;
    end
    check("bounce_latency", first_s, 10);
    check("bounce_count", n_sp - b_sp, 1);

    // Glitch of 3 cycles on btn_reset.
    idle(10);
    q_before = q;
    b_rp = n_rp; b_rl = n_rlvl;
    for (int i = 0; i < 12; i++) step(1'b0, i < 3, 1'b0);
    check("glitch_r_count", n_rp - b_rp, 0);
    check("glitch_level", n_rlvl - b_rl, 0);
    check("glitch_q", q, int'(q_before));

    // Simultaneous presses.
    idle(10);
    q_before = q;
    b_sp = n_sp; b_rp = n_rp; b_cf = n_cf;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
    idle(10);
    check("conf_count", n_cf - b_cf, 1);
    check("conf_s_count", n_sp - b_sp, 0);
    check("conf_r_count", n_rp - b_rp, 0);
    check("conf_q", q, int'(q_before));

    // Presses offset by one cycle.
    b_cf = n_cf;
    first_s = -1; first_r = -1;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, i >= 1, 1'b0);
      if (s_pulse === 1'b1 && first_s < 0) first_s = i;
      if (r_pulse === 1'b1 && first_r < 0) first_r = i;
    end
    check("offset_s_latency", first_s, 5);
    check("offset_r_latency", first_r, 6);
    check("offset_q", q, 0);
    check("offset_conf", n_cf - b_cf, 0);

    // Reset in the middle of a count.
    idle(10);
    b_sp = n_sp;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    first_s = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (s_pulse === 1'b1 && first_s < 0) first_s = i;
    end
    check("midrst_latency", first_s, 5);
    check("midrst_count", n_sp - b_sp, 1);

    // Random holds with bounce and occasional resets.
    idle(10);
    for (int blk = 0; blk < 300; blk++) begin
      cs  = 1'($urandom_range(0, 1));
      cr  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        step(($urandom_range(0, 5) == 0) ? !cs : cs,
             ($urandom_range(0, 5) == 0) ? !cr : cr,
             $urandom_range(0, 99) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
